two_complement_converter_fsm: RTL and testbench
===============================================

Name: two_complement_converter_fsm

Overview:
- Bit-serial two's-complement (negation) converter.
- Consumes an operand LSB-first, one bit per rising clock edge, and emits the negated operand LSB-first on the same cycle.
- Rule: copy bits up to and including the first 1; invert every bit after it.
- Sits on a serial datapath between a shift-out source and a shift-in sink. It has no word-length knowledge; a word boundary is marked by reset.

Parameters:
- none (single-bit serial datapath; word length is unbounded).

Ports:
- clk    input   1  system clock; all state updates on rising edge
- reset  input   1  asynchronous, active-low reset; 0 forces the FSM to its initial state immediately
- in     input   1  serial operand bit, LSB first, one bit per clock cycle
- out    output  1  serial result bit, combinational (Mealy) from current state and `in`

Behaviour:
- One clock; reset is asynchronous and active-low.
- States (2, held in one flip-flop or a 1-bit enum):
  - COPY: no 1 seen yet in the current word.
  - INVERT: a 1 has already been consumed.
- Reset:
  - reset = 0 drives the state to COPY asynchronously, independent of clk.
  - While reset = 0 the state stays COPY, so out = in.
- Output (Mealy, zero latency):
  - COPY: out = in.
  - INVERT: out = ~in.
  - out is valid in the same cycle the bit is presented; no pipeline delay.
- Transitions, evaluated on rising clk while reset = 1:
  - COPY with in = 1 -> INVERT. The triggering 1 is output as 1, because the output is computed in COPY.
  - COPY with in = 0 -> COPY.
  - INVERT with any in -> INVERT. This state is absorbing until the next reset.
- Boundary conditions:
  - All-zero word: stays in COPY, out is all zeros (negation of 0 is 0).
  - First bit is 1: that bit outputs 1; every later bit is inverted.
  - Reset mid-word: conversion aborts, state returns to COPY at once, and the next word starts clean.
  - Reset deassertion near a clock edge: deassert synchronously to clk in the system. The FSM samples `in` only on the first rising edge after deassertion.
  - X/Z on in: out follows combinationally. State must not leave COPY on a non-1 value in simulation; use an explicit `in == 1'b1` compare.
- Overflow (most-negative value) is not detected. The output bit stream is the natural modular result.

Decomposition:
- Shared package: state typedef (COPY = 1'b0, INVERT = 1'b1) and the reset-active level constant (RST_ACTIVE = 1'b0).
- No sub-module. One state register process plus one combinational next-state/output process.

Test Plan:
- Word 0,0,0,1,0,1,1,1,0,1,0,0 (time order, LSB first) after reset pulse -> out 0,0,0,1,1,0,0,0,1,0,1,1.
- Word 1,1,1,1,1 after reset -> out 1,0,0,0,0; state is INVERT from the second bit onward.
- Word 0,0,0,0,0 after reset -> out 0,0,0,0,0; state stays COPY throughout.
- Word 0,0,0,1,0 after reset -> out 0,0,0,1,1.
- Reset mid-word: feed 1,0 (state INVERT), pull reset low between edges -> state is COPY immediately and out equals in while low. Release, then feed 0,1,1 -> out 0,1,0.
- Back-to-back words with a reset between them -> the second word's output is independent of the first (re-run case 1 after case 2 and check identical results).

Source files
------------

// File: rtl/two_complement_converter_fsm_pkg.sv
// Shared types for the bit-serial two's-complement converter.
// State encoding and reset polarity live here so top and bench agree.
package two_complement_converter_fsm_pkg;

  typedef enum logic {
    COPY   = 1'b0,
    INVERT = 1'b1
  } state_t;

  localparam logic RST_ACTIVE = 1'b0;

endpackage

// File: rtl/two_complement_converter_fsm.sv
// Bit-serial negation, LSB first: copy through the first 1, invert afterwards.
// Output is Mealy (same-cycle); reset marks the word boundary.
module two_complement_converter_fsm
  import two_complement_converter_fsm_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic in,
  output logic out
);

  state_t state, state_nxt;

  always_ff @(posedge clk or negedge reset) begin
    if (reset == RST_ACTIVE) state <= COPY;
    else                     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    out       = in;
    case (state)
      COPY: begin
        // Explicit compare keeps X/Z on in from leaving COPY in simulation.
        if (in == 1'b1) state_nxt = INVERT;
      end
      INVERT: out = ~in;
      default: state_nxt = COPY;
    endcase
  end

endmodule

// File: tb/tb_two_complement_converter_fsm.sv
// Directed bench for the serial two's-complement converter.
module tb_two_complement_converter_fsm;
  import two_complement_converter_fsm_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic in = 1'b0;
  logic out;
  int   checks = 0;
  int   failures = 0;

  two_complement_converter_fsm dut (
    .clk  (clk),
    .reset(reset),
    .in   (in),
    .out  (out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Hold reset low across one rising edge, release on a falling edge.
  task automatic do_reset();
    @(negedge clk);
    in    = 1'b0;
    reset = 1'b0;
    #1 chk("rst_state", dut.state, COPY);
    @(negedge clk);
    reset = 1'b1;
  endtask

  // Bit i of w/e is time slot i (LSB first). Inputs change on falling edges.
  task automatic run_word(input string tag, input int n, input logic [15:0] w,
                          input logic [15:0] e);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      in = w[i];
      #1;
      chk($sformatf("%s_out[%0d]", tag, i), out, e[i]);
      chk($sformatf("%s_st[%0d]", tag, i), dut.state, seen ? INVERT : COPY);
      if (w[i] == 1'b1) seen = 1'b1;
    end
  endtask

  initial begin
    // Reset held from time 0: COPY, out follows in.
    #2;
    chk("init_state", dut.state, COPY);
    in = 1'b1; #1 chk("init_out1", out, 1'b1);
    in = 1'b0; #1 chk("init_out0", out, 1'b0);
    @(negedge clk);
    reset = 1'b1;

    run_word("w1", 12, 16'b0000_0010_1110_1000, 16'b0000_1101_0001_1000);
    do_reset();
    run_word("ones", 5, 16'b1_1111, 16'b0_0001);
    do_reset();
    run_word("zeros", 5, 16'b0_0000, 16'b0_0000);
    do_reset();
    run_word("w4", 5, 16'b0_1000, 16'b1_1000);

    // Reset mid-word: 1,0 puts the FSM in INVERT, then reset between edges.
    do_reset();
    run_word("mid", 2, 16'b00_01, 16'b00_11);
    #2;
    reset = 1'b0;
    #1 chk("mid_async_state", dut.state, COPY);
    chk("mid_low_out0", out, 1'b0);
    in = 1'b1;
    #1 chk("mid_low_out1", out, 1'b1);
    @(posedge clk);
    #1 chk("mid_low_hold", dut.state, COPY);
    @(negedge clk);
    in    = 1'b0;
    reset = 1'b1;
    run_word("post", 3, 16'b110, 16'b010);

    // Back-to-back: first word after the all-ones word must match case 1.
    do_reset();
    run_word("ones2", 5, 16'b1_1111, 16'b0_0001);
    do_reset();
    run_word("w1b", 12, 16'b0000_0010_1110_1000, 16'b0000_1101_0001_1000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
